scoreboard_display_sched: RTL and testbench

Time-multiplexing scheduler for the 8-digit seven-segment scoreboard. Divides the system clock into a digit refresh rate, steps a 3-bit digit index, and drives the active-low anode lines and the 4-bit nibble for a downstream segment decoder. Arbitrates the display between the live score and a one-shot message requester, such as a "GAME OVER" glyph string. All switches happen at frame boundaries, so the display never tears.

---
 rtl/scoreboard_pkg.sv | 23 ++
 rtl/refresh_prescaler.sv | 29 ++
 rtl/scoreboard_display_sched.sv | 111 +++++++++++
 tb/tb_scoreboard_display_sched.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared constants, display-state type and nibble helpers for the scoreboard display.
package scoreboard_pkg;

  localparam int unsigned NUM_DIGITS  = 8;
  localparam logic [3:0]  BLANK_GLYPH = 4'hF;

  typedef enum logic {SCORE, MSG} disp_state_t;

  function automatic logic [3:0] nibble_at(input logic [31:0] w, input logic [2:0] k);
    return w[{k, 2'b00} +: 4];
  endfunction

  // Digit k (k >= 1) is a leading zero when it and every digit to its left are zero.
  function automatic logic lz_blank(input logic [31:0] w, input logic [2:0] k);
    logic z;
    z = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      if (j >= 32'(k)) z = z & (w[4*j +: 4] == 4'h0);
    end
    return z && (k != 3'd0);
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Divides the system clock into digit slots and steps the 3-bit digit index.
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic       slot_tick,
  output logic [2:0] idx
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] pcnt;

  assign slot_tick = (pcnt == PW'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (slot_tick) begin
      pcnt <= '0;
      idx  <= idx + 3'd1;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/scoreboard_display_sched.sv
// Seven-segment scan scheduler: arbitrates live score vs. one-shot message at frame boundaries.
module scoreboard_display_sched
  import scoreboard_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned HOLD_FRAMES = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] score_bcd,
  input  logic        score_load,
  input  logic        msg_req,
  input  logic [31:0] msg_data,
  output logic        msg_ack,
  output logic        msg_active,
  output logic [7:0]  an,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        frame_tick
);

  localparam int unsigned HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;

  logic          slot_tick;
  logic [2:0]    idx;
  logic [2:0]    nidx;
  logic          boundary;
  disp_state_t   state, nstate;
  logic [31:0]   pend, disp, msg;
  logic [31:0]   ndisp, nmsg;
  logic [HW-1:0] hold, nhold;
  logic          nack;
  logic [3:0]    nnib;
  logic          nblank;

  refresh_prescaler #(.REFRESH_DIV(REFRESH_DIV)) u_presc (
    .clk       (clk),
    .reset     (reset),
    .slot_tick (slot_tick),
    .idx       (idx)
  );

  assign boundary   = slot_tick && (idx == 3'd7);
  assign frame_tick = boundary;
  assign msg_active = (state == MSG);

  // Digit outputs are registered from the post-edge view (next idx, next frame
  // contents) so that an, digit and blank all switch on the same clock edge.
  always_comb begin
    nidx   = idx + 3'd1;
    nstate = state;
    nhold  = hold;
    nmsg   = msg;
    ndisp  = disp;
    nack   = 1'b0;
    nnib   = '0;
    nblank = 1'b0;
    if (boundary) begin
      ndisp = score_load ? score_bcd : pend;
      case (state)
        SCORE: begin
          if (msg_req) begin
            nstate = MSG;
            nmsg   = msg_data;
            nack   = 1'b1;
            nhold  = HW'(HOLD_FRAMES - 1);
          end
        end
        MSG: begin
          if (hold == '0) nstate = SCORE;
          else            nhold  = hold - HW'(1);
        end
        default: nstate = SCORE;
      endcase
    end
    if (nstate == MSG) begin
      nnib   = nibble_at(nmsg, nidx);
      nblank = (nnib == BLANK_GLYPH);
    end else begin
      nnib   = nibble_at(ndisp, nidx);
      nblank = lz_blank(ndisp, nidx);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SCORE;
      hold    <= '0;
      pend    <= '0;
      disp    <= '0;
      msg     <= '1;
      msg_ack <= 1'b0;
      an      <= 8'hFE;
      digit   <= '0;
      blank   <= 1'b0;
    end else begin
      state   <= nstate;
      hold    <= nhold;
      msg     <= nmsg;
      disp    <= ndisp;
      msg_ack <= nack;
      if (score_load) pend <= score_bcd;
      if (slot_tick) begin
        an    <= ~(8'h01 << nidx);
        digit <= nnib;
        blank <= nblank;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_display_sched.sv
// Directed bench for scoreboard_display_sched with REFRESH_DIV = 4, HOLD_FRAMES = 2.
module tb_scoreboard_display_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] score_bcd;
  logic        score_load;
  logic        msg_req;
  logic [31:0] msg_data;
  logic        msg_ack;
  logic        msg_active;
  logic [7:0]  an;
  logic [3:0]  digit;
  logic        blank;
  logic        frame_tick;

  int vectors    = 0;
  int miscompares = 0;
  int n          = 0;

  localparam logic [7:0] AN_TAB [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  scoreboard_display_sched #(.REFRESH_DIV(4), .HOLD_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .score_bcd  (score_bcd),
    .score_load (score_load),
    .msg_req    (msg_req),
    .msg_data   (msg_data),
    .msg_ack    (msg_ack),
    .msg_active (msg_active),
    .an         (an),
    .digit      (digit),
    .blank      (blank),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic run_to(input int t);
    while (n < t) tick();
  endtask

  // Sample slot k of the frame starting at cycle base, one cycle into the slot.
  task automatic check_slot(input string tag, input int base, input int k,
                            input logic [3:0] d, input logic b);
    run_to(base + 4*k + 1);
    check({tag, "_an"},    an,    AN_TAB[k]);
    check({tag, "_digit"}, digit, d);
    check({tag, "_blank"}, blank, b);
  endtask

  initial begin
    int acks, actv, ticks;
    reset = 1'b1; score_bcd = '0; score_load = 1'b0; msg_req = 1'b0; msg_data = '0;
    @(negedge clk); @(negedge clk);
    check("rst_an", an, 8'hFE);
    check("rst_digit", digit, 4'h0);
    check("rst_blank", blank, 1'b0);
    check("rst_ftick", frame_tick, 1'b0);
    check("rst_ack", msg_ack, 1'b0);
    check("rst_active", msg_active, 1'b0);
    reset = 1'b0;
    n = 0;

    // 1: score 0 scan, two frames
    for (int c = 0; c < 64; c++) begin
      check("t1_an", an, AN_TAB[(c/4)%8]);
      check("t1_ftick", frame_tick, (c % 32) == 31);
      check("t1_digit", digit, 4'h0);
      check("t1_blank", blank, ((c/4)%8) != 0);
      tick();
    end

    // 2: mid-frame load waits for boundary
    run_to(69);
    score_bcd = 32'h00001234; score_load = 1'b1;
    tick();
    score_load = 1'b0; score_bcd = '0;
    check_slot("t2_pre3", 64, 3, 4'h0, 1'b1);
    check_slot("t2_d0", 96, 0, 4'h4, 1'b0);
    check_slot("t2_d1", 96, 1, 4'h3, 1'b0);
    check_slot("t2_d2", 96, 2, 4'h2, 1'b0);
    check_slot("t2_d3", 96, 3, 4'h1, 1'b0);
    check_slot("t2_d4", 96, 4, 4'h0, 1'b1);
    check_slot("t2_d7", 96, 7, 4'h0, 1'b1);

    // 3: load on the boundary cycle bypasses pend
    run_to(127);
    check("t3_ftick", frame_tick, 1'b1);
    score_bcd = 32'h00000099; score_load = 1'b1;
    tick();
    score_load = 1'b0; score_bcd = '0;
    check_slot("t3_d0", 128, 0, 4'h9, 1'b0);
    check_slot("t3_d1", 128, 1, 4'h9, 1'b0);
    check_slot("t3_d2", 128, 2, 4'h0, 1'b1);

    // 4: message request held high
    msg_data = 32'hFFF0F1F2; msg_req = 1'b1;
    run_to(159);
    check("t4_ack_pre", msg_ack, 1'b0);
    check("t4_act_pre", msg_active, 1'b0);
    tick();
    check("t4_ack", msg_ack, 1'b1);
    check("t4_act", msg_active, 1'b1);
    check("t4_an0", an, 8'hFE);
    check("t4_dig0", digit, 4'h2);
    tick();
    check("t4_ack_post", msg_ack, 1'b0);
    check_slot("t4_d1", 160, 1, 4'hF, 1'b1);
    check_slot("t4_d2", 160, 2, 4'h1, 1'b0);
    // 5: score update during the message
    score_bcd = 32'h00000500; score_load = 1'b1;
    tick();
    score_load = 1'b0; score_bcd = '0;
    check_slot("t4_d3", 160, 3, 4'hF, 1'b1);
    check_slot("t4_d4", 160, 4, 4'h0, 1'b0);
    check_slot("t4_d5", 160, 5, 4'hF, 1'b1);
    check_slot("t4_d7", 160, 7, 4'hF, 1'b1);
    check_slot("t4_f2d0", 192, 0, 4'h2, 1'b0);
    run_to(223);
    check("t4_act_last", msg_active, 1'b1);
    tick();
    check("t4_act_end", msg_active, 1'b0);
    check("t4_ack_end", msg_ack, 1'b0);
    check_slot("t5_d0", 224, 0, 4'h0, 1'b0);
    check_slot("t5_d1", 224, 1, 4'h0, 1'b0);
    check_slot("t5_d2", 224, 2, 4'h5, 1'b0);
    check_slot("t5_d3", 224, 3, 4'h0, 1'b1);
    check_slot("t5_d7", 224, 7, 4'h0, 1'b1);
    run_to(255);
    check("t4_ack2_pre", msg_ack, 1'b0);
    tick();
    check("t4_ack2", msg_ack, 1'b1);
    check("t4_act2", msg_active, 1'b1);

    // 6: asynchronous reset mid-message
    run_to(266);
    #2 reset = 1'b1;
    #1;
    check("t6_act", msg_active, 1'b0);
    check("t6_an", an, 8'hFE);
    check("t6_ack", msg_ack, 1'b0);
    check("t6_digit", digit, 4'h0);
    check("t6_blank", blank, 1'b0);
    msg_req = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    n = 0;
    acks = 0; actv = 0; ticks = 0;
    for (int c = 0; c < 80; c++) begin
      if (msg_ack)    acks++;
      if (msg_active) actv++;
      if (frame_tick) ticks++;
      tick();
    end
    check("t6_no_ack", acks, 0);
    check("t6_no_active", actv, 0);
    check("t6_ftick_count", ticks, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
